// File: rtl/snn_pkg.sv
// Shared constants, state encodings and index helpers for the SNN
// input/output memory block.
package snn_pkg;

  localparam int IF_DIM  = 25;
  localparam int OUT_DIM = 21;
  localparam int N_TS    = 2;
  localparam int ADDR_W  = 12;
  localparam int TS_W    = 2;
  localparam int ODATA_W = 13;

  localparam int IF_SZ  = IF_DIM * IF_DIM;
  localparam int OUT_SZ = OUT_DIM * OUT_DIM;
  localparam int IF_AW  = $clog2(IF_SZ);
  localparam int OUT_AW = $clog2(OUT_SZ);
  localparam int TS_IW  = (N_TS > 1) ? $clog2(N_TS) : 1;

  localparam logic [ADDR_W-1:0] IF_LIMIT  = ADDR_W'(IF_SZ);
  localparam logic [ADDR_W-1:0] OUT_LIMIT = ADDR_W'(OUT_SZ);
  localparam logic [ADDR_W-1:0] OUT_LAST  = ADDR_W'(OUT_SZ - 1);

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOADING,
    LD_LOADED
  } load_state_e;

  typedef enum logic [2:0] {
    RO_IDLE,
    RO_START,
    RO_HDR,
    RO_DATA,
    RO_DONE
  } ro_state_e;

  typedef struct packed {
    load_state_e load_st;
    ro_state_e   ro_st;
  } snn_dbg_t;

  // Timesteps are numbered 1..N_TS on the wire; storage rows are 0-based.
  function automatic logic ts_ok(input logic [TS_W-1:0] ts);
    return (ts != '0) && (int'(ts) <= N_TS);
  endfunction

  function automatic logic [TS_IW-1:0] ts_idx(input logic [TS_W-1:0] ts);
    logic [TS_W-1:0] t;
    t = ts - TS_W'(1);
    return t[TS_IW-1:0];
  endfunction

endpackage

// File: rtl/snn_out_streamer.sv
// Result array with written-bitmap and the readout FSM that streams
// start / header / data / done tokens to the host.
module snn_out_streamer
  import snn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_bitmap,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [TS_W-1:0]    wr_ts,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ODATA_W-1:0] wr_data,
  input  logic               comp_done,
  output logic               start_valid,
  input  logic               start_ready,
  output logic               start_data,
  output logic               hdr_valid,
  input  logic               hdr_ready,
  output logic [TS_W-1:0]    hdr_ts,
  output logic [TS_W-1:0]    hdr_layer,
  output logic               osp_valid,
  input  logic               osp_ready,
  output logic [ADDR_W-1:0]  osp_addr,
  output logic [ODATA_W-1:0] osp_data,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               done_data,
  output ro_state_e          state
);

  // Handshake: a token transfers on a cycle where valid && ready; valid and
  // payload come from registers and hold until that cycle.
  logic [ODATA_W-1:0] res_mem [0:N_TS-1][0:OUT_SZ-1];
  logic               written [0:N_TS-1][0:OUT_SZ-1];

  ro_state_e         state_q;
  logic [TS_W-1:0]   ts_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] look_addr;
  logic [ODATA_W-1:0] look_data;
  logic              wr_hit;

  assign state    = state_q;
  assign wr_ready = (state_q == RO_IDLE);
  assign wr_hit   = wr_valid && wr_ready && ts_ok(wr_ts) && (wr_addr < OUT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TS; t++) begin
        for (int a = 0; a < OUT_SZ; a++) begin
          res_mem[t][a] <= '0;
          written[t][a] <= 1'b0;
        end
      end
    end else begin
      if (wr_hit) begin
        res_mem[ts_idx(wr_ts)][wr_addr[OUT_AW-1:0]] <= wr_data;
        written[ts_idx(wr_ts)][wr_addr[OUT_AW-1:0]] <= 1'b1;
      end
      // A new load phase invalidates every result, including one written this cycle.
      if (clear_bitmap) begin
        for (int t = 0; t < N_TS; t++) begin
          for (int a = 0; a < OUT_SZ; a++) written[t][a] <= 1'b0;
        end
      end
    end
  end

  // Payload for the next data token, fetched one step ahead so osp_data is a register.
  always_comb begin
    look_addr = (state_q == RO_HDR) ? '0 : addr_q + ADDR_W'(1);
    look_data = '0;
    if (look_addr < OUT_LIMIT && written[ts_idx(ts_q)][look_addr[OUT_AW-1:0]])
      look_data = res_mem[ts_idx(ts_q)][look_addr[OUT_AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RO_IDLE;
      ts_q     <= TS_W'(1);
      addr_q   <= '0;
      osp_data <= '0;
    end else begin
      case (state_q)
        RO_IDLE: if (comp_done) begin
          state_q <= RO_START;
          ts_q    <= TS_W'(1);
          addr_q  <= '0;
        end
        RO_START: if (start_ready) state_q <= RO_HDR;
        RO_HDR: if (hdr_ready) begin
          state_q  <= RO_DATA;
          addr_q   <= '0;
          osp_data <= look_data;
        end
        RO_DATA: if (osp_ready) begin
          if (addr_q == OUT_LAST) begin
            if (ts_q == TS_W'(N_TS)) state_q <= RO_DONE;
            else begin
              ts_q    <= ts_q + TS_W'(1);
              state_q <= RO_HDR;
            end
          end else begin
            addr_q   <= look_addr;
            osp_data <= look_data;
          end
        end
        RO_DONE: if (done_ready) state_q <= RO_IDLE;
        default: state_q <= RO_IDLE;
      endcase
    end
  end

  assign start_valid = (state_q == RO_START);
  assign start_data  = 1'b1;
  assign hdr_valid   = (state_q == RO_HDR);
  assign hdr_ts      = ts_q;
  assign hdr_layer   = TS_W'(1);
  assign osp_valid   = (state_q == RO_DATA);
  assign osp_addr    = addr_q;
  assign done_valid  = (state_q == RO_DONE);
  assign done_data   = 1'b1;

endmodule

// File: rtl/snn_io_mem.sv
// Ifmap spike store with load FSM and single-spike read port; result
// collection and host readout live in snn_out_streamer.
module snn_io_mem
  import snn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [TS_W-1:0]    ld_ts,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic               ld_data,
  input  logic               load_done,
  output logic               loaded,
  input  logic               rd_valid,
  output logic               rd_ready,
  input  logic [TS_W-1:0]    rd_ts,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rsp_valid,
  output logic               rsp_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [TS_W-1:0]    wr_ts,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ODATA_W-1:0] wr_data,
  input  logic               comp_done,
  output logic               start_valid,
  input  logic               start_ready,
  output logic               start_data,
  output logic               hdr_valid,
  input  logic               hdr_ready,
  output logic [TS_W-1:0]    hdr_ts,
  output logic [TS_W-1:0]    hdr_layer,
  output logic               osp_valid,
  input  logic               osp_ready,
  output logic [ADDR_W-1:0]  osp_addr,
  output logic [ODATA_W-1:0] osp_data,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               done_data,
  output snn_dbg_t           dbg_state
);

  load_state_e ld_st_q;
  ro_state_e   ro_state;
  logic        ifmap [0:N_TS-1][0:IF_SZ-1];
  logic        ld_hit;
  logic        rd_hit;

  // load_start restarts the phase from any state and outranks load_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_st_q <= LD_IDLE;
    else if (load_start) ld_st_q <= LD_LOADING;
    else if (ld_st_q == LD_LOADING && load_done) ld_st_q <= LD_LOADED;
  end

  assign loaded   = (ld_st_q == LD_LOADED);
  assign ld_ready = (ld_st_q == LD_LOADING);
  assign rd_ready = 1'b1;

  assign ld_hit = ld_valid && ld_ready && ts_ok(ld_ts) && (ld_addr < IF_LIMIT);
  assign rd_hit = rd_valid && loaded && ts_ok(rd_ts) && (rd_addr < IF_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TS; t++) begin
        for (int a = 0; a < IF_SZ; a++) ifmap[t][a] <= 1'b0;
      end
    end else if (ld_hit) begin
      ifmap[ts_idx(ld_ts)][ld_addr[IF_AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
    end else begin
      rsp_valid <= rd_valid;
      rsp_data  <= rd_hit ? ifmap[ts_idx(rd_ts)][rd_addr[IF_AW-1:0]] : 1'b0;
    end
  end

  snn_out_streamer u_streamer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_bitmap (load_start),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_ts        (wr_ts),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .comp_done    (comp_done),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_data   (start_data),
    .hdr_valid    (hdr_valid),
    .hdr_ready    (hdr_ready),
    .hdr_ts       (hdr_ts),
    .hdr_layer    (hdr_layer),
    .osp_valid    (osp_valid),
    .osp_ready    (osp_ready),
    .osp_addr     (osp_addr),
    .osp_data     (osp_data),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_data    (done_data),
    .state        (ro_state)
  );

  assign dbg_state = {ld_st_q, ro_state};

endmodule

// File: tb/tb_snn_io_mem.sv
// Self-checking bench for snn_io_mem: table-driven spike reads plus a
// token scoreboard for the result readout stream.
module tb_snn_io_mem;
  import snn_pkg::*;

  localparam int TOK_W = 2 + ADDR_W + ODATA_W;
  localparam int FULL_TOKENS = 1 + N_TS * (1 + OUT_SZ) + 1;

  logic               clk, rst_n;
  logic               load_start, ld_valid, ld_ready, ld_data, load_done, loaded;
  logic [TS_W-1:0]    ld_ts, rd_ts, wr_ts, hdr_ts, hdr_layer;
  logic [ADDR_W-1:0]  ld_addr, rd_addr, wr_addr, osp_addr;
  logic               rd_valid, rd_ready, rsp_valid, rsp_data;
  logic               wr_valid, wr_ready, comp_done;
  logic [ODATA_W-1:0] wr_data, osp_data;
  logic               start_valid, start_ready, start_data;
  logic               hdr_valid, hdr_ready, osp_valid, osp_ready;
  logic               done_valid, done_ready, done_data;
  snn_dbg_t           dbg_state;

  int checks = 0;
  int errors = 0;

  logic [TOK_W-1:0] exp_q[$];
  logic [0:0]       rsp_q[$];
  logic [ODATA_W-1:0] m_res [1:N_TS][0:OUT_SZ-1];

  typedef struct {
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] addr;
    logic              exp;
  } rd_vec_t;
  rd_vec_t vec [15];

  int ready_mode = 0;
  int tok_cycles = 0;

  snn_io_mem dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_ts(ld_ts), .ld_addr(ld_addr), .ld_data(ld_data),
    .load_done(load_done), .loaded(loaded),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ts(rd_ts), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ts(wr_ts),
    .wr_addr(wr_addr), .wr_data(wr_data), .comp_done(comp_done),
    .start_valid(start_valid), .start_ready(start_ready), .start_data(start_data),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_ts(hdr_ts), .hdr_layer(hdr_layer),
    .osp_valid(osp_valid), .osp_ready(osp_ready), .osp_addr(osp_addr), .osp_data(osp_data),
    .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [TOK_W-1:0] tok(input logic [1:0] k, input logic [ADDR_W-1:0] a,
                                           input logic [ODATA_W-1:0] d);
    return {k, a, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Ready drivers: 0 = all high, 1 = osp_ready toggles, 2 = random stalls
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        start_ready = 1'b1; hdr_ready = 1'b1; done_ready = 1'b1;
        osp_ready = ~osp_ready;
      end
      2: begin
        start_ready = 1'($urandom_range(0, 1));
        hdr_ready   = 1'($urandom_range(0, 1));
        osp_ready   = 1'($urandom_range(0, 1));
        done_ready  = 1'($urandom_range(0, 1));
      end
      default: begin
        start_ready = 1'b1; hdr_ready = 1'b1; osp_ready = 1'b1; done_ready = 1'b1;
      end
    endcase
  end

  // Stream scoreboard: one token at a time, stable while stalled
  logic [TOK_W-1:0] cur_tok, held_tok;
  logic             cur_rdy;
  int               nv;
  bit               held = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      nv = int'(start_valid) + int'(hdr_valid) + int'(osp_valid) + int'(done_valid);
      cur_tok = '0;
      cur_rdy = 1'b0;
      if (start_valid) begin cur_tok = tok(2'd0, '0, ODATA_W'(start_data)); cur_rdy = start_ready; end
      if (hdr_valid) begin cur_tok = tok(2'd1, ADDR_W'(hdr_ts), ODATA_W'(hdr_layer)); cur_rdy = hdr_ready; end
      if (osp_valid) begin cur_tok = tok(2'd2, osp_addr, osp_data); cur_rdy = osp_ready; end
      if (done_valid) begin cur_tok = tok(2'd3, '0, ODATA_W'(done_data)); cur_rdy = done_ready; end
      if (nv > 1) chk("one_valid", 32'(nv), 32'd1);
      if (nv != 0) begin
        tok_cycles++;
        chk("wr_ready_busy", 32'(wr_ready), 32'd0);
        if (held) chk("stall_stable", 32'(cur_tok), 32'(held_tok));
        if (cur_rdy) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_token actual=%0h required=none", cur_tok);
          end else begin
            chk("token", 32'(cur_tok), 32'(exp_q.pop_front()));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_tok = cur_tok;
        end
      end else begin
        if (held) chk("valid_dropped", 32'(nv), 32'd1);
        held = 1'b0;
      end
    end
  end

  // Read-response scoreboard with one-cycle latency check
  bit rd_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_prev <= 1'b0;
    else rd_prev <= rd_valid && rd_ready;
  end

  always @(negedge clk) begin
    if (rst_n && (rd_prev || rsp_valid)) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(rd_prev));
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_rsp actual=%0h required=none", rsp_data);
        end else begin
          chk("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
        end
      end
    end
  end

  // Driver tasks
  task automatic load(input int ts, input int addr, input logic d);
    ld_valid = 1'b1; ld_ts = TS_W'(ts); ld_addr = ADDR_W'(addr); ld_data = d;
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic run_reads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rd_valid = 1'b1; rd_ts = vec[i].ts; rd_addr = vec[i].addr;
      rsp_q.push_back(vec[i].exp);
      cyc();
    end
    rd_valid = 1'b0;
    cyc(); cyc();
    chk("rsp_drained", 32'(rsp_q.size()), 32'd0);
  endtask

  task automatic do_write(input int ts, input int addr, input logic [ODATA_W-1:0] d);
    int n;
    n = 0;
    while (!wr_ready && n < 3000) begin cyc(); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL wr_ready_wait actual=0 required=1");
    end
    wr_valid = 1'b1; wr_ts = TS_W'(ts); wr_addr = ADDR_W'(addr); wr_data = d;
    cyc();
    wr_valid = 1'b0;
    if (ts >= 1 && ts <= N_TS && addr < OUT_SZ) m_res[ts][addr] = d;
  endtask

  task automatic clear_model();
    for (int t = 1; t <= N_TS; t++)
      for (int a = 0; a < OUT_SZ; a++) m_res[t][a] = '0;
  endtask

  task automatic push_readout();
    exp_q.push_back(tok(2'd0, '0, ODATA_W'(1)));
    for (int t = 1; t <= N_TS; t++) begin
      exp_q.push_back(tok(2'd1, ADDR_W'(t), ODATA_W'(1)));
      for (int a = 0; a < OUT_SZ; a++) exp_q.push_back(tok(2'd2, ADDR_W'(a), m_res[t][a]));
    end
    exp_q.push_back(tok(2'd3, '0, ODATA_W'(1)));
  endtask

  // poke_at >= 0: mid-stream comp_done and a write attempt, both must be ignored
  task automatic readout(input int poke_at, input bit check_cycles);
    int n;
    push_readout();
    tok_cycles = 0;
    comp_done = 1'b1;
    cyc();
    comp_done = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      if (n == poke_at) begin
        comp_done = 1'b1; wr_valid = 1'b1; wr_ts = 1; wr_addr = 7; wr_data = 13'h0AAA;
      end else begin
        comp_done = 1'b0; wr_valid = 1'b0;
      end
      cyc();
      n++;
    end
    comp_done = 1'b0; wr_valid = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL readout_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    cyc(); cyc();
    chk("readout_idle", 32'(dbg_state.ro_st), 32'(RO_IDLE));
    if (check_cycles) chk("readout_cycles", 32'(tok_cycles), 32'(FULL_TOKENS));
  endtask

  initial begin
    vec[0]  = '{1, 624, 1};  vec[1]  = '{2, 0, 0};    vec[2]  = '{2, 1, 1};
    vec[3]  = '{1, 0, 1};    vec[4]  = '{2, 624, 0};  vec[5]  = '{2, 623, 1};
    vec[6]  = '{3, 5, 0};    vec[7]  = '{0, 1, 0};    vec[8]  = '{1, 625, 0};
    vec[9]  = '{1, 624, 0};
    vec[10] = '{1, 624, 1};  vec[11] = '{1, 5, 1};    vec[12] = '{2, 1, 1};
    vec[13] = '{2, 0, 0};    vec[14] = '{1, 1029, 0};

    rst_n = 1'b0; load_start = 0; load_done = 0; ld_valid = 0; ld_ts = 0; ld_addr = 0;
    ld_data = 0; rd_valid = 0; rd_ts = 0; rd_addr = 0; wr_valid = 0; wr_ts = 0;
    wr_addr = 0; wr_data = 0; comp_done = 0;
    start_ready = 1; hdr_ready = 1; osp_ready = 1; done_ready = 1;
    clear_model();

    // Reset state
    #1;
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_rd_ready", 32'(rd_ready), 1);
    chk("rst_rsp", 32'({rsp_valid, rsp_data}), 0);
    chk("rst_valids", 32'({start_valid, hdr_valid, osp_valid, done_valid}), 0);
    chk("rst_dbg", 32'(dbg_state), 32'({LD_IDLE, RO_IDLE}));
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Load ts1 all ones, ts2 alternating
    load_start = 1; cyc(); load_start = 0;
    chk("ld_ready_loading", 32'(ld_ready), 1);
    for (int t = 1; t <= N_TS; t++)
      for (int a = 0; a < IF_SZ; a++) load(t, a, (t == 1) ? 1'b1 : 1'(a % 2));
    load_done = 1; cyc(); load_done = 0;
    chk("loaded_set", 32'(loaded), 1);
    run_reads(0, 8);

    // Handshake outside LOADING, start+done together, out-of-range loads
    chk("ld_ready_loaded", 32'(ld_ready), 0);
    load(2, 0, 1'b1);
    load_start = 1; load_done = 1; cyc(); load_start = 0; load_done = 0;
    clear_model();
    chk("start_wins_loaded", 32'(loaded), 0);
    chk("start_wins_ready", 32'(ld_ready), 1);
    run_reads(9, 9);
    load(3, 5, 1'b0); load(0, 1, 1'b0); load(1, 1029, 1'b0); load(2, 700, 1'b1);
    load_done = 1; cyc(); load_done = 0;
    chk("loaded_again", 32'(loaded), 1);
    run_reads(10, 14);

    // Full write then readout with all readies high
    for (int t = 1; t <= N_TS; t++)
      for (int a = 0; a < OUT_SZ; a++) do_write(t, a, ODATA_W'(((t - 1) * OUT_SZ + a) % 8192));
    ready_mode = 0;
    readout(-1, 1'b1);

    // osp_ready toggling, with ignored comp_done / write mid-stream
    ready_mode = 1;
    readout(300, 1'b0);
    ready_mode = 2;
    readout(-1, 1'b0);

    // Fresh load phase, single write plus dropped out-of-range writes
    ready_mode = 0;
    cyc();
    load_start = 1; cyc(); load_start = 0;
    clear_model();
    load_done = 1; cyc(); load_done = 0;
    do_write(1, 5, 13'h1FFF);
    do_write(3, 5, 13'h0123);
    do_write(0, 6, 13'h0456);
    do_write(1, 441, 13'h0777);
    ready_mode = 2;
    readout(-1, 1'b0);

    // Reset in the middle of a readout
    ready_mode = 0;
    cyc();
    push_readout();
    comp_done = 1; cyc(); comp_done = 0;
    repeat (100) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valids", 32'({start_valid, hdr_valid, osp_valid, done_valid}), 0);
    chk("midrst_wr_ready", 32'(wr_ready), 1);
    chk("midrst_loaded", 32'(loaded), 0);
    exp_q.delete();
    rsp_q.delete();
    clear_model();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    readout(-1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
